// File: rtl/nonrestoring_div32by16.sv
// nonrestoring_div32by16
//   Sequential radix-2 non-restoring divider: 2*WIDTH-bit dividend divided
//   by a WIDTH-bit divisor, one quotient bit per clock. Companion to the
//   16x16->32 multiplier: its product can be fed straight in as dividend.
//
//   Optional build macro: DIV_SIGNED_EN adds the sgn input (two's complement
//   operands, truncating division) and a NEG stage after FIX.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation
//   start      request, sampled only in IDLE
//   dividend   2*WIDTH-bit numerator, captured on accepted start
//   divisor    WIDTH-bit denominator, captured on accepted start
//   sgn        (DIV_SIGNED_EN only) signed request, captured on start
//   busy       high in CHECK/ITER/FIX(/NEG)
//   done       one-cycle completion pulse; results valid with it and held
//   quotient   result quotient (all ones on div0/ovf)
//   remainder  result remainder (dividend low half on div0/ovf)
//   div0       divisor was zero
//   ovf        quotient does not fit in WIDTH bits
module nonrestoring_div32by16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
`ifdef DIV_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div0,
  output logic                 ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_FIX,
    S_NEG,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH:0]       p_q, p_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_div0_q, pend_div0_d;
  logic                 pend_ovf_q, pend_ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 div0_q, div0_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   mag_dvd;
  logic [WIDTH-1:0]     mag_dvs;
  logic [WIDTH:0]       p_shift, p_step, p_fix;
  logic                 range_ovf;

`ifdef DIV_SIGNED_EN
  logic                 sgn_q, sgn_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 dvd_neg, dvs_neg;
  logic [2*WIDTH:0]     lim_pos, lim_neg;

  // Magnitudes feed the unsigned core. A signed quotient magnitude must stay
  // below 2^(W-1) (positive) or 2^(W-1)+1 (negative); compare the dividend
  // magnitude against limit*divisor instead of dividing.
  always_comb begin
    dvd_neg   = sgn_q & dvd_q[2*WIDTH-1];
    dvs_neg   = sgn_q & dvs_q[WIDTH-1];
    mag_dvd   = dvd_neg ? -dvd_q : dvd_q;
    mag_dvs   = dvs_neg ? -dvs_q : dvs_q;
    lim_pos   = (2*WIDTH+1)'(mag_dvs) << (WIDTH-1);
    lim_neg   = lim_pos + (2*WIDTH+1)'(mag_dvs);
    range_ovf = sgn_q & ({1'b0, mag_dvd} >= ((dvd_neg ^ dvs_neg) ? lim_neg : lim_pos));
  end
`else
  always_comb begin
    mag_dvd   = dvd_q;
    mag_dvs   = dvs_q;
    range_ovf = 1'b0;
  end
`endif

  // One non-restoring step: P stays within [-D, D), so modulo-2^(W+1)
  // arithmetic is exact even though the shifted value may wrap.
  always_comb begin
    p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    p_step  = p_q[WIDTH] ? p_shift + {1'b0, dvs_q} : p_shift - {1'b0, dvs_q};
    p_fix   = p_q[WIDTH] ? p_q + {1'b0, dvs_q} : p_q;
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    pend_div0_d = pend_div0_q;
    pend_ovf_d  = pend_ovf_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    div0_d      = div0_q;
    ovf_d       = ovf_q;
`ifdef DIV_SIGNED_EN
    sgn_d       = sgn_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d       = dividend;
          dvs_d       = divisor;
          div0_d      = 1'b0;
          ovf_d       = 1'b0;
          pend_div0_d = 1'b0;
          pend_ovf_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          sgn_d       = sgn;
`endif
          state_d     = S_CHECK;
        end
      end

      // Special cases also pass through FIX so their latency is fixed at 3.
      S_CHECK: begin
        dvs_d = mag_dvs;
`ifdef DIV_SIGNED_EN
        negq_d = dvd_neg ^ dvs_neg;
        negr_d = dvd_neg;
`endif
        if (mag_dvs == '0) begin
          pend_div0_d = 1'b1;
          q_d         = '1;
          p_d         = {1'b0, dvd_q[WIDTH-1:0]};
          state_d     = S_FIX;
        end else if ((mag_dvd[2*WIDTH-1:WIDTH] >= mag_dvs) || range_ovf) begin
          pend_ovf_d  = 1'b1;
          q_d         = '1;
          p_d         = {1'b0, dvd_q[WIDTH-1:0]};
          state_d     = S_FIX;
        end else begin
          p_d     = {1'b0, mag_dvd[2*WIDTH-1:WIDTH]};
          q_d     = mag_dvd[WIDTH-1:0];
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        p_d   = p_step;
        q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (pend_div0_q || pend_ovf_q) begin
          quot_d  = q_q;
          rem_d   = p_q[WIDTH-1:0];
          div0_d  = pend_div0_q;
          ovf_d   = pend_ovf_q;
          state_d = S_DONE;
        end else begin
          p_d = p_fix;
`ifdef DIV_SIGNED_EN
          state_d = S_NEG;
`else
          quot_d  = q_q;
          rem_d   = p_fix[WIDTH-1:0];
          state_d = S_DONE;
`endif
        end
      end

`ifdef DIV_SIGNED_EN
      S_NEG: begin
        quot_d  = negq_q ? -q_q : q_q;
        rem_d   = negr_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CHECK) || (state_d == S_ITER) ||
             (state_d == S_FIX)   || (state_d == S_NEG);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      pend_div0_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q       <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      pend_div0_q <= pend_div0_d;
      pend_ovf_q  <= pend_ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      div0_q      <= div0_d;
      ovf_q       <= ovf_d;
`ifdef DIV_SIGNED_EN
      sgn_q       <= sgn_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nonrestoring_div32by16.sv
// tb_nonrestoring_div32by16
//   Self-checking bench for nonrestoring_div32by16: directed cases, start
//   while busy / in DONE, reset abort, and random operands compared with a
//   plain-arithmetic reference model. Honours DIV_SIGNED_EN when defined.
module tb_nonrestoring_div32by16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
`ifdef DIV_SIGNED_EN
  logic        sgn;
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  logic        busy, done, div0, ovf;
  logic [15:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nonrestoring_div32by16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
`ifdef DIV_SIGNED_EN
    .sgn       (sgn),
`endif
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on wide integers, saturate when the
  // quotient does not fit the result width.
  task automatic model(input logic [31:0] a, input logic [15:0] b, input bit s,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic d0, output logic ov);
    longint na, nb, qq, rr;
    d0 = 1'b0;
    ov = 1'b0;
    q  = '1;
    r  = a[15:0];
    if (b == 16'h0) begin
      d0 = 1'b1;
      return;
    end
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'(a);
      nb = longint'(b);
    end
    qq = na / nb;
    rr = na % nb;
    if (s ? (qq > 32767 || qq < -32768) : (qq > 65535)) begin
      ov = 1'b1;
    end else begin
      q = qq[15:0];
      r = rr[15:0];
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input bit s, input string tag);
    int          lat;
    logic [15:0] eq, er;
    logic        ed0, eov;
    logic [47:0] prod;
    @(negedge clk);
    dividend = a;
    divisor  = b;
`ifdef DIV_SIGNED_EN
    sgn      = s;
`endif
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat      = 1;
    chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    model(a, b, s, eq, er, ed0, eov);
    chk({tag, ".lat"}, lat, (ed0 || eov) ? 32'd3 : 32'(19 + EXTRA));
    chk({tag, ".q"}, {16'b0, quotient}, {16'b0, eq});
    chk({tag, ".r"}, {16'b0, remainder}, {16'b0, er});
    chk({tag, ".div0"}, {31'b0, div0}, {31'b0, ed0});
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eov});
    chk({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    if (!s && !ed0 && !eov) begin
      prod = 48'(quotient) * 48'(b) + 48'(remainder);
      chk({tag, ".inv"}, prod[31:0], a);
      chk({tag, ".rlt"}, {31'b0, remainder < b}, 32'd1);
    end
  endtask

  initial begin
    int          lat;
    bit          seen;
    logic [15:0] b;
    logic [31:0] a;
    int unsigned cat;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    sgn      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.q", {16'b0, quotient}, 32'd0);
    chk("rst.r", {16'b0, remainder}, 32'd0);
    chk("rst.flags", {30'b0, div0, ovf}, 32'd0);
    rst = 1'b0;

    do_op(32'h000F4240, 16'h03E8, 1'b0, "d1");
    chk("d1.q_lit", {16'b0, quotient}, 32'h03E8);
    do_op(32'hFFFE0001, 16'hFFFF, 1'b0, "d2");
    do_op(32'h00010000, 16'h0002, 1'b0, "d3");
    chk("d3.q_lit", {16'b0, quotient}, 32'h8000);
    do_op(32'h12345678, 16'h0000, 1'b0, "d4");
    chk("d4.r_lit", {16'b0, remainder}, 32'h5678);
    do_op(32'h00020000, 16'h0002, 1'b0, "d5");
    chk("d5.ovf_lit", {31'b0, ovf}, 32'd1);

    // Start pulses while busy (cycle 5) and in the DONE cycle.
    @(negedge clk);
    dividend = 32'h000F4240;
    divisor  = 16'h03E8;
`ifdef DIV_SIGNED_EN
    sgn      = 1'b0;
`endif
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        dividend = 32'h00000064;
        divisor  = 16'h0005;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ign.lat", lat, 32'(19 + EXTRA));
    chk("ign.q", {16'b0, quotient}, 32'h03E8);
    chk("ign.r", {16'b0, remainder}, 32'h0000);
    dividend = 32'h00000064;
    divisor  = 16'h0005;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done.busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("ign_done.busy2", {31'b0, busy}, 32'd0);
    chk("ign_done.done", {31'b0, done}, 32'd0);

    // Reset at cycle 10 of a request aborts it without a done.
    dividend = 32'h00010000;
    divisor  = 16'h0002;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.q", {16'b0, quotient}, 32'd0);
    chk("abort.r", {16'b0, remainder}, 32'd0);
    chk("abort.flags", {30'b0, div0, ovf}, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort.no_done", {31'b0, seen}, 32'd0);
    do_op(32'h000F4240, 16'h03E8, 1'b0, "after_abort");

    // Random unsigned operands, biased toward the edge categories.
    for (int i = 0; i < 1500; i++) begin
      cat = $urandom_range(0, 7);
      b   = 16'($urandom_range(1, 65535));
      a   = $urandom;
      case (cat)
        0: begin b = 16'h0001; a = {16'h0, a[15:0]}; end
        1: a = {b - 16'h1, a[15:0]};
        2: a = {16'($urandom) % b, a[15:0]};
        3: b = 16'h0000;
        4: b = 16'h0001;
        default: ;
      endcase
      do_op(a, b, 1'b0, "rnd");
    end

`ifdef DIV_SIGNED_EN
    do_op(32'hFFFFFFF9, 16'h0002, 1'b1, "s1");
    chk("s1.q_lit", {16'b0, quotient}, 32'hFFFD);
    chk("s1.r_lit", {16'b0, remainder}, 32'hFFFF);
    do_op(32'h80000000, 16'hFFFF, 1'b1, "s2");
    chk("s2.ovf_lit", {31'b0, ovf}, 32'd1);
    do_op(32'hFFFF8000, 16'h0001, 1'b1, "s3");
    do_op(32'h00008000, 16'h0001, 1'b1, "s4");
    for (int i = 0; i < 500; i++) begin
      cat = $urandom_range(0, 3);
      a   = $urandom;
      b   = 16'($urandom);
      if (cat == 0) a = 32'($signed(a[19:0]));
      if (cat == 1) a = 32'($signed(a[23:0]));
      do_op(a, b, 1'b1, "srnd");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
